row_serial_multiplier: RTL

//  Parametrised sequential array multiplier. Accumulates ROWS_PER_CYCLE

---
 rtl/row_serial_multiplier.sv | 133 +++++++++++++
 1 files changed

// File: rtl/row_serial_multiplier.sv
// Row-serial array multiplier: sums ROWS_PER_CYCLE partial-product rows
// per clock into a 2*WIDTH accumulator, with valid/ready handshakes on
// both sides and an optional two's-complement mode.
module row_serial_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 1,
  parameter bit SIGNED_EN      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  // Extended multiplicand, pre-shifted so that row k of the current step
  // is simply mshift_q << j for j in 0..ROWS_PER_CYCLE-1.
  logic [PW-1:0]   mshift_q, mshift_d;
  // Multiplier bits still to be consumed; bit 0 is always row k.
  logic [WIDTH-1:0] q_q, q_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [PW-1:0]   row;
  logic [PW-1:0]   row_sum;
  logic            last_step;
  logic            capture_mode;

  assign last_step    = (cnt_q == CW'(WIDTH - ROWS_PER_CYCLE));
  assign capture_mode = signed_mode & SIGNED_EN;

  // Sum this clock's rows into the accumulator; in signed mode the final
  // row (row WIDTH-1) carries negative weight and is subtracted.
  always_comb begin
    row     = '0;
    row_sum = acc_q;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      row = q_q[j] ? (mshift_q << j) : '0;
      if (mode_q && last_step && (j == ROWS_PER_CYCLE - 1)) begin
        row_sum = row_sum - row;
      end else begin
        row_sum = row_sum + row;
      end
    end
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    mshift_d  = mshift_q;
    q_d       = q_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d   = capture_mode;
          mshift_d = capture_mode ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                                  : {{WIDTH{1'b0}}, multiplicand};
          q_d      = multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = row_sum;
        cnt_d    = cnt_q + CW'(ROWS_PER_CYCLE);
        q_d      = q_q >> ROWS_PER_CYCLE;
        mshift_d = mshift_q << ROWS_PER_CYCLE;
        if (last_step) begin
          product_d = row_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mshift_q  <= '0;
      q_q       <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mshift_q  <= mshift_d;
      q_q       <= q_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule
